// File: rtl/seg7_scan_driver.sv
// Multiplexed hex driver for an N-digit common-anode seven-segment display.
// Buffers a written word and swaps it in only at a frame boundary so a frame never mixes two words.
module seg7_scan_driver #(
    parameter int N_DIGITS  = 8,
    parameter int PRESCALER = 100000
) (
    input  logic                  clk,
    input  logic                  cl,
    input  logic                  w,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic                  pending,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = $clog2(PRESCALER);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(PRESCALER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_word_q, pend_word_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*N_DIGITS-1:0] disp_word_q, disp_word_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                  pending_q, pending_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic       tick;
    logic       commit;
    logic       nz_above;
    logic       blank;
    logic [3:0] cur_nib;
    logic       cur_dp;

    // Slot timer is a down-counter: loaded with PRESCALER-1, slot ends at zero.
    always_comb begin
        tick   = (cnt_q == '0);
        cnt_d  = tick ? CNT_TOP : cnt_q - CNT_W'(1);
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        commit      = tick && (idx_q == IDX_LAST) && pending_q;
        disp_word_d = commit ? pend_word_q : disp_word_q;
        disp_dp_d   = commit ? pend_dp_q : disp_dp_q;
        pend_word_d = w ? din : pend_word_q;
        pend_dp_d   = w ? dp_in : pend_dp_q;
        pending_d   = pending_q;
        if (commit) pending_d = 1'b0;
        if (w)      pending_d = 1'b1;
    end

    // Digit selection and leading-zero detection for the digit currently in its slot.
    always_comb begin
        nz_above = 1'b0;
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        an_d     = '1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_q) && disp_word_q[4*j +: 4] != 4'h0) nz_above = 1'b1;
            if (j == int'(idx_q)) begin
                cur_nib = disp_word_q[4*j +: 4];
                cur_dp  = disp_dp_q[j];
                an_d[j] = 1'b0;
            end
        end
        blank = blank_lz && (idx_q != '0) && !nz_above;
        seg_d = hex_to_seg(cur_nib);
        dp_d  = ~cur_dp;
        if (blank) begin
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cl) begin
            cnt_q       <= CNT_TOP;
            idx_q       <= '0;
            pend_word_q <= '0;
            pend_dp_q   <= '0;
            disp_word_q <= '0;
            disp_dp_q   <= '0;
            pending_q   <= 1'b0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_word_q <= pend_word_d;
            pend_dp_q   <= pend_dp_d;
            disp_word_q <= disp_word_d;
            disp_dp_q   <= disp_dp_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign pending = pending_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=8, PRESCALER=4 (digit slot = 4 cycles, frame = 32).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        cl = 1'b1;
    logic        w = 1'b0;
    logic [31:0] din = '0;
    logic [7:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        pending;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;

    seg7_scan_driver #(.N_DIGITS(8), .PRESCALER(4)) dut (
        .clk(clk), .cl(cl), .w(w), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
        .pending(pending), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since cl was last released
    always @(posedge clk) cyc <= cl ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] an_e, input logic [6:0] seg_e, input logic dp_e);
        chk({tag, ".an"}, 32'(an), 32'(an_e));
        chk({tag, ".seg"}, 32'(seg), 32'(seg_e));
        chk({tag, ".dp"}, 32'(dp), 32'(dp_e));
    endtask

    // advance to the falling edge following rising edge n
    task automatic go(input int n);
        int guard = 0;
        while (cyc < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (cyc != n) begin
            errs++;
            $error("FAIL go_timeout observed=%0d expected=%0d", cyc, n);
        end
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] p);
        din   = d;
        dp_in = p;
        w     = 1'b1;
        @(negedge clk);
        w     = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_out("reset", 8'hFF, 7'h7F, 1'b1);
        chk("reset.pending", 32'(pending), 32'd0);
        cl = 1'b0;
        go(1);
        chk_out("release.d0", 8'hFE, 7'b1000000, 1'b1);

        go(8);
        chk("pend_before_w", 32'(pending), 32'd0);
        write(32'h89ABCDEF, 8'h01);
        chk("pend_after_w", 32'(pending), 32'd1);
        go(31);
        chk("pend_before_commit", 32'(pending), 32'd1);
        go(32);
        chk("pend_after_commit", 32'(pending), 32'd0);
        go(33);
        chk_out("w1.d0", 8'hFE, 7'b0001110, 1'b0);

        go(44);
        write(32'h12345670, 8'h80);
        chk("pend_w2", 32'(pending), 32'd1);
        go(49);
        chk_out("tear.d4_old", 8'hEF, 7'b0000011, 1'b1);
        go(61);
        chk_out("tear.d7_old", 8'h7F, 7'b0000000, 1'b1);
        go(63);
        chk("pend_w2_hold", 32'(pending), 32'd1);
        go(64);
        chk("pend_w2_commit", 32'(pending), 32'd0);
        go(65);
        chk_out("w2.d0", 8'hFE, 7'b1000000, 1'b1);

        go(69);
        write(32'hCAFE0123, 8'h00);
        go(93);
        chk_out("w2.d7", 8'h7F, 7'b1111001, 1'b0);
        go(95);
        write(32'h00000A05, 8'h02);
        chk("coll.pending", 32'(pending), 32'd1);
        go(97);
        chk_out("coll.A.d0", 8'hFE, 7'b0110000, 1'b1);
        go(125);
        chk_out("coll.A.d7", 8'h7F, 7'b1000110, 1'b1);
        go(127);
        chk("coll.pend_hold", 32'(pending), 32'd1);
        go(128);
        chk("coll.pend_clear", 32'(pending), 32'd0);
        blank_lz = 1'b1;
        go(129);
        chk_out("coll.B.d0", 8'hFE, 7'b0010010, 1'b1);
        go(133);
        chk_out("lz.d1", 8'hFD, 7'b1000000, 1'b0);
        go(137);
        chk_out("lz.d2", 8'hFB, 7'b0001000, 1'b1);
        go(141);
        chk_out("lz.d3", 8'hFF, 7'h7F, 1'b1);
        write(32'h00000000, 8'h04);
        go(157);
        chk_out("lz.d7", 8'hFF, 7'h7F, 1'b1);
        go(161);
        chk_out("zero.d0", 8'hFE, 7'b1000000, 1'b1);
        go(165);
        chk_out("zero.d1", 8'hFF, 7'h7F, 1'b1);
        go(169);
        chk_out("zero.d2_dp", 8'hFF, 7'h7F, 1'b1);
        go(172);
        blank_lz = 1'b0;
        go(173);
        chk_out("live_lz.d3", 8'hF7, 7'b1000000, 1'b1);

        go(176);
        write(32'h11111111, 8'hFF);
        chk("midcl.pending", 32'(pending), 32'd1);
        go(180);
        cl = 1'b1;
        @(negedge clk);
        chk_out("midcl.reset", 8'hFF, 7'h7F, 1'b1);
        chk("midcl.pend_clr", 32'(pending), 32'd0);
        cl = 1'b0;
        go(1);
        chk_out("midcl.d0", 8'hFE, 7'b1000000, 1'b1);
        go(5);
        chk_out("midcl.d1", 8'hFD, 7'b1000000, 1'b1);
        go(33);
        chk_out("midcl.nocommit", 8'hFE, 7'b1000000, 1'b1);
        chk("midcl.pend_end", 32'(pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
